// File: rtl/sec_ksa_pkg.sv
// Shared helpers for the masked Kogge-Stone adder pipeline.
// SECKSA_REFRESH_EN adds the output refresh words to the randomness budget.
package sec_ksa_pkg;

`ifdef SECKSA_REFRESH_EN
   localparam bit REFRESH_EN = 1'b1;
`else
   localparam bit REFRESH_EN = 1'b0;
`endif

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Random words consumed by one SecAnd gadget: one word per unordered share pair.
   function automatic int secand_words(input int n_shares);
      return n_shares * (n_shares - 1) / 2;
   endfunction

   function automatic int randnum_calc(input int l, input int n_shares, input bit refresh);
      return l * n_shares * (n_shares - 1) + (refresh ? n_shares - 1 : 0);
   endfunction

   function automatic int share_lsb(input int share, input int width);
      return share * width;
   endfunction

   // Maps the unordered pair {i,j}, i != j, onto 0 .. n*(n-1)/2-1.
   function automatic int pair_index(input int i, input int j, input int n_shares);
      int lo;
      int hi;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return lo * n_shares - lo * (lo + 1) / 2 + (hi - lo - 1);
   endfunction

endpackage

// File: rtl/sec_and.sv
// Registered N-share DOM AND gadget: all partial products are registered
// (cross terms blinded by a pair-shared random word) before any share is recombined.
module sec_and
   import sec_ksa_pkg::*;
#(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 3
)(
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          ena,
   input  logic [K_WIDTH*N_SHARES-1:0]                   a,
   input  logic [K_WIDTH*N_SHARES-1:0]                   b,
   input  logic [K_WIDTH*secand_words(N_SHARES)-1:0]     r,
   output logic [K_WIDTH*N_SHARES-1:0]                   c
);

   logic [K_WIDTH-1:0] term_r [N_SHARES][N_SHARES];

   // NOTE: this small product array is a register bank, not a memory, so it is
   // reset element by element; leaving it unreset would let stale products leak out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SHARES; i++)
            for (int j = 0; j < N_SHARES; j++)
               term_r[i][j] <= '0;
      end else if (ena) begin
         for (int i = 0; i < N_SHARES; i++) begin
            for (int j = 0; j < N_SHARES; j++) begin
               if (i == j)
                  term_r[i][j] <= a[share_lsb(i, K_WIDTH) +: K_WIDTH]
                                & b[share_lsb(i, K_WIDTH) +: K_WIDTH];
               else
                  term_r[i][j] <= (a[share_lsb(i, K_WIDTH) +: K_WIDTH]
                                 & b[share_lsb(j, K_WIDTH) +: K_WIDTH])
                                ^ r[share_lsb(pair_index(i, j, N_SHARES), K_WIDTH) +: K_WIDTH];
            end
         end
      end
   end

   // NOTE: every bit of c gets a default before the loop, so no latch is inferred.
   always_comb begin
      c = '0;
      for (int i = 0; i < N_SHARES; i++)
         for (int j = 0; j < N_SHARES; j++)
            c[share_lsb(i, K_WIDTH) +: K_WIDTH] = c[share_lsb(i, K_WIDTH) +: K_WIDTH] ^ term_r[i][j];
   end

endmodule

// File: rtl/sec_ksa_pipe.sv
// Boolean-masked Kogge-Stone adder, one operation per enabled cycle, latency L+2.
// Optional build macro SECKSA_REFRESH_EN refreshes the output shares with extra rnd words.
module sec_ksa_pipe
   import sec_ksa_pkg::*;
#(
   parameter int K_WIDTH   = 32,
   parameter int N_SHARES  = 3,
   parameter int MASKWIDTH = K_WIDTH * N_SHARES,
   parameter int L         = clog2(K_WIDTH),
   parameter int RANDNUM   = randnum_calc(L, N_SHARES, REFRESH_EN)
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   input  logic                         dvld,
   input  logic [K_WIDTH*RANDNUM-1:0]   rnd,
   input  logic [MASKWIDTH-1:0]         x,
   input  logic [MASKWIDTH-1:0]         y,
   output logic [MASKWIDTH-1:0]         z,
   output logic                         ovld
);

   localparam int NRW = secand_words(N_SHARES) * K_WIDTH;

   function automatic logic [MASKWIDTH-1:0] shl_shares(input logic [MASKWIDTH-1:0] v,
                                                       input int s);
      logic [MASKWIDTH-1:0] res;
      res = '0;
      for (int i = 0; i < N_SHARES; i++)
         res[share_lsb(i, K_WIDTH) +: K_WIDTH] = v[share_lsb(i, K_WIDTH) +: K_WIDTH] << s;
      return res;
   endfunction

   logic [MASKWIDTH-1:0] p0_r    [0:L];
   logic [MASKWIDTH-1:0] g_lin_r [1:L];
   logic [MASKWIDTH-1:0] g_c     [0:L];
   logic [MASKWIDTH-1:0] p_c     [0:L-1];
   logic [MASKWIDTH-1:0] z_next;
   logic [L+1:0]         vld_r;

   // Gadget k takes rnd words [k*NRW +: NRW]: 0 = stage-0 generate, 2j-1 = stage-j g, 2j = stage-j p.
   sec_and #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES)) u_and_g0 (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .a   (x),
      .b   (y),
      .r   (rnd[0 +: NRW]),
      .c   (g_c[0])
   );

   assign p_c[0] = p0_r[0];

   for (genvar j = 1; j <= L; j++) begin : g_stage
      logic [MASKWIDTH-1:0] and_g;

      sec_and #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES)) u_and_g (
         .clk (clk),
         .rst (rst),
         .ena (ena),
         .a   (p_c[j-1]),
         .b   (shl_shares(g_c[j-1], 1 << (j - 1))),
         .r   (rnd[(2*j-1)*NRW +: NRW]),
         .c   (and_g)
      );

      // Group generate and group propagate never overlap, so XOR stands in for OR.
      assign g_c[j] = g_lin_r[j] ^ and_g;

      if (j < L) begin : g_prop
         sec_and #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES)) u_and_p (
            .clk (clk),
            .rst (rst),
            .ena (ena),
            .a   (p_c[j-1]),
            .b   (shl_shares(p_c[j-1], 1 << (j - 1))),
            .r   (rnd[2*j*NRW +: NRW]),
            .c   (p_c[j])
         );
      end
   end

`ifdef SECKSA_REFRESH_EN
   localparam int REF_LSB = 2 * L * NRW;
   logic [MASKWIDTH-1:0] refresh_mask;

   // Shares 0..N-2 take one fresh word each; the last share takes their XOR, so the mask sums to zero.
   always_comb begin
      logic [K_WIDTH-1:0] acc;
      refresh_mask = '0;
      acc          = '0;
      for (int i = 0; i < N_SHARES - 1; i++) begin
         refresh_mask[share_lsb(i, K_WIDTH) +: K_WIDTH] = rnd[REF_LSB + share_lsb(i, K_WIDTH) +: K_WIDTH];
         acc = acc ^ rnd[REF_LSB + share_lsb(i, K_WIDTH) +: K_WIDTH];
      end
      refresh_mask[share_lsb(N_SHARES - 1, K_WIDTH) +: K_WIDTH] = acc;
   end

   assign z_next = p0_r[L] ^ shl_shares(g_c[L], 1) ^ refresh_mask;
`else
   assign z_next = p0_r[L] ^ shl_shares(g_c[L], 1);
`endif

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= L; j++) p0_r[j] <= '0;
         for (int j = 1; j <= L; j++) g_lin_r[j] <= '0;
         z     <= '0;
         vld_r <= '0;
      end else if (ena) begin
         p0_r[0] <= x ^ y;
         for (int j = 1; j <= L; j++) begin
            p0_r[j]    <= p0_r[j-1];
            g_lin_r[j] <= g_c[j-1];
         end
         z     <= z_next;
         vld_r <= {vld_r[L:0], dvld};
      end
   end

   assign ovld = vld_r[L+1];

endmodule

// File: tb/tb_sec_ksa_pipe.sv
// Directed self-checking bench for sec_ksa_pipe (32-bit/3-share and 8-bit/2-share instances).
module tb_sec_ksa_pipe;
   import sec_ksa_pkg::*;

   localparam int K   = 32;
   localparam int N   = 3;
   localparam int MW  = K * N;
   localparam int LL  = clog2(K);
   localparam int RN  = randnum_calc(LL, N, REFRESH_EN);
   localparam int K8  = 8;
   localparam int N8  = 2;
   localparam int MW8 = K8 * N8;
   localparam int RN8 = randnum_calc(clog2(K8), N8, REFRESH_EN);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ena = 1'b1;
   logic            dvld = 1'b0;
   logic [K*RN-1:0] rnd = '0;
   logic [MW-1:0]   x = '0;
   logic [MW-1:0]   y = '0;
   logic [MW-1:0]   z;
   logic            ovld;

   logic              ena8 = 1'b1;
   logic              dvld8 = 1'b0;
   logic [K8*RN8-1:0] rnd8 = '0;
   logic [MW8-1:0]    x8 = '0;
   logic [MW8-1:0]    y8 = '0;
   logic [MW8-1:0]    z8;
   logic              ovld8;

   int n_checks = 0;
   int n_fail   = 0;

   sec_ksa_pipe #(.K_WIDTH(K), .N_SHARES(N)) dut (
      .clk(clk), .rst(rst), .ena(ena), .dvld(dvld), .rnd(rnd),
      .x(x), .y(y), .z(z), .ovld(ovld)
   );

   sec_ksa_pipe #(.K_WIDTH(K8), .N_SHARES(N8)) dut8 (
      .clk(clk), .rst(rst), .ena(ena8), .dvld(dvld8), .rnd(rnd8),
      .x(x8), .y(y8), .z(z8), .ovld(ovld8)
   );

   always #5 clk = ~clk;

   function automatic logic [MW-1:0] mask32(input logic [K-1:0] v);
      logic [MW-1:0] s;
      logic [K-1:0]  acc;
      acc = v;
      for (int i = 0; i < N - 1; i++) begin
         s[i*K +: K] = K'($urandom);
         acc = acc ^ s[i*K +: K];
      end
      s[(N-1)*K +: K] = acc;
      return s;
   endfunction

   function automatic logic [K-1:0] unmask32(input logic [MW-1:0] v);
      logic [K-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r = r ^ v[i*K +: K];
      return r;
   endfunction

   function automatic logic [MW8-1:0] mask8(input logic [K8-1:0] v);
      logic [K8-1:0] a;
      a = K8'($urandom);
      return {v ^ a, a};
   endfunction

   // Advance to the next falling edge and present fresh randomness to both instances.
   task automatic tick();
      @(negedge clk);
      for (int w = 0; w < RN; w++) rnd[w*K +: K] = K'($urandom);
      for (int w = 0; w < RN8; w++) rnd8[w*K8 +: K8] = K8'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (ovld !== 1'b0) begin n_fail++; $display("FAIL reset_ovld: got %b want 0", ovld); end
      n_checks++;
      if (z !== '0) begin n_fail++; $display("FAIL reset_z: got %h want 0", z); end
      n_checks++;
      if (ovld8 !== 1'b0) begin n_fail++; $display("FAIL reset_ovld8: got %b want 0", ovld8); end
      n_checks++;
      if (z8 !== '0) begin n_fail++; $display("FAIL reset_z8: got %h want 0", z8); end
      rst = 1'b0;
   endtask

   task automatic test_single_wrap();
      int seen;
      int lat;
      tick();
      dvld = 1'b1;
      x = mask32(32'hFFFF_FFFF);
      y = mask32(32'h0000_0001);
      seen = 0;
      lat  = -1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         dvld = 1'b0;
         if (ovld === 1'b1) begin
            seen++;
            if (lat < 0) lat = c;
            n_checks++;
            if (unmask32(z) !== 32'h0000_0000) begin
               n_fail++; $display("FAIL wrap_value: got %h want 00000000", unmask32(z));
            end
         end
      end
      n_checks++;
      if (lat != 7) begin n_fail++; $display("FAIL wrap_latency: got %0d want 7", lat); end
      n_checks++;
      if (seen != 1) begin n_fail++; $display("FAIL wrap_pulses: got %0d want 1", seen); end
   endtask

   task automatic test_back_to_back();
      int first;
      int last;
      int cnt;
      first = -1; last = -1; cnt = 0;
      for (int c = 0; c < 45; c++) begin
         tick();
         if (ovld === 1'b1) begin
            if (first < 0) first = c;
            last = c;
            cnt++;
            n_checks++;
            if (unmask32(z) !== 32'h9999_9999) begin
               n_fail++; $display("FAIL b2b_value: cycle %0d got %h want 99999999", c, unmask32(z));
            end
         end
         if (c < 20) begin
            dvld = 1'b1;
            x = mask32(32'h1234_5678);
            y = mask32(32'h8765_4321);
         end else begin
            dvld = 1'b0;
         end
      end
      n_checks++;
      if (first != 7) begin n_fail++; $display("FAIL b2b_first: got %0d want 7", first); end
      n_checks++;
      if (last != 26) begin n_fail++; $display("FAIL b2b_last: got %0d want 26", last); end
      n_checks++;
      if (cnt != 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", cnt); end
   endtask

   task automatic test_ena_stall();
      logic [MW-1:0] z_snap;
      logic [K-1:0]  exp_v [2];
      int            exp_c [2];
      int            cnt;
      exp_v[0] = 32'h8000_0000; exp_c[0] = 10;
      exp_v[1] = 32'hDFD1_0456; exp_c[1] = 11;
      cnt = 0;
      z_snap = '0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (c == 3) z_snap = z;
         if (c == 6) begin
            n_checks++;
            if (z !== z_snap) begin n_fail++; $display("FAIL stall_hold_z: got %h want %h", z, z_snap); end
         end
         if (ovld === 1'b1) begin
            if (cnt < 2) begin
               n_checks++;
               if (c != exp_c[cnt]) begin
                  n_fail++; $display("FAIL stall_cycle: op %0d got %0d want %0d", cnt, c, exp_c[cnt]);
               end
               n_checks++;
               if (unmask32(z) !== exp_v[cnt]) begin
                  n_fail++; $display("FAIL stall_value: op %0d got %h want %h", cnt, unmask32(z), exp_v[cnt]);
               end
            end
            cnt++;
         end
         case (c)
            0: begin dvld = 1'b1; x = mask32(32'h7FFF_FFFF); y = mask32(32'h0000_0001); end
            1: begin dvld = 1'b1; x = mask32(32'hDEAD_BEEF); y = mask32(32'h0123_4567); end
            2: dvld = 1'b0;
            3, 4, 5: begin
               ena  = 1'b0;
               dvld = 1'b1;
               x = mask32(K'($urandom));
               y = mask32(K'($urandom));
            end
            6: begin ena = 1'b1; dvld = 1'b0; end
            default: dvld = 1'b0;
         endcase
      end
      n_checks++;
      if (cnt != 2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", cnt); end
   endtask

   task automatic test_reset_midflight();
      int seen;
      int lat;
      for (int c = 0; c < 7; c++) begin
         tick();
         if (c < 4) begin
            dvld = 1'b1;
            x = mask32(32'h0000_FFFF);
            y = mask32(32'h0000_0001);
         end else begin
            dvld = 1'b0;
         end
      end
      tick();
      n_checks++;
      if (ovld !== 1'b1) begin n_fail++; $display("FAIL midrst_before: ovld got %b want 1", ovld); end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (ovld !== 1'b0) begin n_fail++; $display("FAIL midrst_ovld: got %b want 0", ovld); end
      n_checks++;
      if (z !== '0) begin n_fail++; $display("FAIL midrst_z: got %h want 0", z); end
      tick();
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (ovld === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL midrst_dropped: got %0d pulses want 0", seen); end
      tick();
      dvld = 1'b1;
      x = mask32(32'hFFFF_0000);
      y = mask32(32'h0001_0000);
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         dvld = 1'b0;
         if (ovld === 1'b1 && lat < 0) begin
            lat = c;
            n_checks++;
            if (unmask32(z) !== 32'h0000_0000) begin
               n_fail++; $display("FAIL postrst_value: got %h want 00000000", unmask32(z));
            end
         end
      end
      n_checks++;
      if (lat != 7) begin n_fail++; $display("FAIL postrst_latency: got %0d want 7", lat); end
   endtask

   task automatic test_exhaustive_k8();
      logic [K8-1:0] exp_q [$];
      logic [K8-1:0] exp_v;
      logic [K8-1:0] xa;
      logic [K8-1:0] ya;
      int            first;
      int            got;
      first = -1;
      got   = 0;
      for (int i = 0; i < 65536 + 10; i++) begin
         tick();
         if (ovld8 === 1'b1) begin
            if (first < 0) first = i;
            got++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL k8_extra: unexpected output %h", z8[7:0] ^ z8[15:8]);
            end else begin
               exp_v = exp_q.pop_front();
               if ((z8[7:0] ^ z8[15:8]) !== exp_v) begin
                  n_fail++; $display("FAIL k8_value: got %h want %h", z8[7:0] ^ z8[15:8], exp_v);
               end
            end
         end
         if (i < 65536) begin
            xa = i[15:8];
            ya = i[7:0];
            dvld8 = 1'b1;
            x8 = mask8(xa);
            y8 = mask8(ya);
            exp_q.push_back(xa + ya);
         end else begin
            dvld8 = 1'b0;
         end
      end
      n_checks++;
      if (first != 5) begin n_fail++; $display("FAIL k8_latency: got %0d want 5", first); end
      n_checks++;
      if (got != 65536) begin n_fail++; $display("FAIL k8_count: got %0d want 65536", got); end
   endtask

`ifdef SECKSA_REFRESH_EN
   task automatic run_fixed(input logic [K-1:0] salt, output logic [MW-1:0] zo);
      zo = '0;
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int w = 0; w < RN; w++) begin
            rnd[w*K +: K] = K'(32'h9E37_79B9 * (c * 64 + w + 1));
            if (w >= RN - (N - 1)) rnd[w*K +: K] = rnd[w*K +: K] ^ salt;
         end
         if (ovld === 1'b1) zo = z;
         if (c == 0) begin
            dvld = 1'b1;
            x = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
            y = {32'h0F0F_0F0F, 32'hA0A0_A0A0, 32'h1234_1234};
         end else begin
            dvld = 1'b0;
         end
      end
   endtask

   task automatic test_refresh();
      logic [MW-1:0] za;
      logic [MW-1:0] zb;
      logic [K-1:0]  exp_v;
      exp_v = (32'h1111_2222 ^ 32'h3333_4444 ^ 32'h5555_6666)
            + (32'h0F0F_0F0F ^ 32'hA0A0_A0A0 ^ 32'h1234_1234);
      run_fixed(32'h0000_0000, za);
      run_fixed(32'h5A5A_0F0F, zb);
      n_checks++;
      if (unmask32(za) !== exp_v) begin n_fail++; $display("FAIL refresh_value: got %h want %h", unmask32(za), exp_v); end
      n_checks++;
      if (unmask32(zb) !== unmask32(za)) begin
         n_fail++; $display("FAIL refresh_unmasked: got %h want %h", unmask32(zb), unmask32(za));
      end
      n_checks++;
      if (zb === za) begin n_fail++; $display("FAIL refresh_shares: got identical shares %h", zb); end
   endtask
`endif

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_wrap();
      test_back_to_back();
      test_ena_stall();
      test_reset_midflight();
`ifdef SECKSA_REFRESH_EN
      test_refresh();
`endif
      test_exhaustive_k8();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sec_ksa_pipe.md
SEC_KSA_PIPE -- requirements
Module: sec_ksa_pipe

Interface
REQ-001 SHALL have parameter K_WIDTH, default 32: adder word width, allowed range 2..64.
REQ-002 SHALL have parameter N_SHARES, default 3: Boolean share count, allowed range 2..8.
REQ-003 SHALL have parameter MASKWIDTH, default K_WIDTH*N_SHARES: packed share-vector width.
REQ-004 SHALL have parameter L, default clog2(K_WIDTH): number of Kogge-Stone prefix stages.
REQ-005 SHALL have parameter RANDNUM, default L*N_SHARES*(N_SHARES-1), plus (N_SHARES-1) when SECKSA_REFRESH_EN is defined: K_WIDTH-bit random words per cycle.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 ena  in  1  global advance enable; low freezes the whole pipeline.
REQ-009 dvld  in  1  input operands valid this cycle.
REQ-010 rnd  in  K_WIDTH*RANDNUM  fresh randomness; the slices of every stage are sampled each enabled cycle.
REQ-011 x  in  MASKWIDTH  Boolean-shared operand x; share i occupies bits [i*K_WIDTH +: K_WIDTH].
REQ-012 y  in  MASKWIDTH  Boolean-shared operand y, packed the same way.
REQ-013 z  out  MASKWIDTH  Boolean-shared sum; XOR of all shares equals (X+Y) mod 2^K_WIDTH.
REQ-014 ovld  out  1  z valid; high for exactly one enabled cycle per accepted input.

Function
REQ-015 Stage 0 SHALL register p0 = x^y sharewise and g0 = SecAnd(x,y).
- One clock per enabled cycle.
REQ-016 Prefix stage j (1..L, shift s=2^(j-1)) SHALL register:
- g = g ^ SecAnd(p, g<<s), sharewise.
- p = SecAnd(p, p<<s) for j<L; p is dropped at stage L.
- p0 is carried alongside every stage.
REQ-017 The output stage SHALL register z = p0 ^ (g<<1), sharewise.
- Latency from an accepted dvld to ovld is L+2 enabled cycles (7 for K_WIDTH=32).
REQ-018 Each stage uses a fixed, disjoint rnd slice of N_SHARES*(N_SHARES-1)/2 words per SecAnd.
- No random word is reused across SecAnd instances in the same cycle.
REQ-019 Throughput SHALL be one operation per enabled cycle.
- Back-to-back dvld is accepted every cycle without bubbles.
REQ-020 A valid bit per stage SHALL track data through the pipeline.
- ovld is the last stage's valid bit.
REQ-021 When ena=0:
- All data and valid registers hold.
- ovld and z are held.
- dvld and rnd are ignored.
REQ-022 Shifts SHALL zero-fill LSBs.
- The carry out of bit K_WIDTH-1 is discarded (wrap-around mod 2^K_WIDTH).
REQ-023 No unmasked value SHALL ever be formed.
- Cross-share terms are combined only after registering inside SecAnd.

Reset
REQ-024 Asserting rst at any time, including mid-operation, SHALL asynchronously clear all data and valid registers.
- ovld=0, z=0.
- In-flight operations are dropped.
REQ-025 The first dvld sampled after rst deasserts SHALL produce ovld exactly L+2 enabled cycles later.

Configuration
REQ-026 SECKSA_REFRESH_EN defined:
- The output stage additionally XORs an (N_SHARES-1)-word refresh mask into z (ISW refresh), using the extra rnd words.
- Latency is unchanged.
REQ-027 SECKSA_REFRESH_EN undefined:
- No refresh logic.
- RANDNUM excludes the extra words.
- z is the unrefreshed sum.

Structure
REQ-028 Package sec_ksa_pkg SHALL hold:
- clog2 and RANDNUM calculation functions.
- The per-SecAnd random-word count constant.
- The share-slice indexing helper.
REQ-029 Sub-module sec_and SHALL implement a registered N_SHARES DOM AND gadget.
- Clock enable: ena.
- Reset: rst.
- The top instantiates 2L copies.

Verification
REQ-030 K=32, N=3; X=0xFFFFFFFF, Y=0x00000001 (random shares), one dvld -> ovld high 7 cycles later, unmasked z=0x00000000.
REQ-031 X=0x12345678, Y=0x87654321, dvld every cycle for 20 cycles with random shares -> 20 consecutive ovld pulses, each unmasking to 0x99999999.
REQ-032 ena low for 3 cycles mid-flight -> ovld delayed by exactly 3 cycles, values unchanged, no duplicate ovld.
REQ-033 rst pulsed while 4 ops in flight -> ovld=0 and z=0 immediately, no ovld for those ops afterward.
REQ-034 K=8, N=2, exhaustive X,Y -> every unmasked z equals (X+Y)&0xFF, latency 5.
REQ-035 SECKSA_REFRESH_EN defined, same shares and rnd except refresh words changed -> unmasked z identical, individual z shares differ.
